psum_expander: RTL and testbench
================================

PSUM_EXPANDER -- requirements
Module: psum_expander

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the narrow (truncated) psum word.
REQ-002 Parameter SEL_WIDTH, default $clog2(DATA_WIDTH): the sel port is SEL_WIDTH+1 bits wide.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: in_data and in_sel are valid this cycle.
REQ-006 Port in_ready, output, 1: the block accepts an input this cycle.
REQ-007 Port in_data, input, DATA_WIDTH: narrow signed (two's complement) psum.
REQ-008 Port in_sel, input, SEL_WIDTH+1: left-shift amount, 0 to 2*DATA_WIDTH-1, captured with in_data.
REQ-009 Port out_valid, output, 1: out_data holds a result.
REQ-010 Port out_ready, input, 1: the consumer accepts out_data this cycle.
REQ-011 Port out_data, output, 2*DATA_WIDTH: expanded signed psum.
REQ-012 Port ovf_sticky, output, 1: set once any accepted input overflowed 2*DATA_WIDTH; cleared only by reset or clr.
REQ-013 Port clr, input, 1: synchronous clear of ovf_sticky and out_count.
REQ-014 Port out_count, output, 16: count of completed output handshakes, wrapping modulo 2^16.

Function
REQ-015 An input handshake occurs when in_valid and in_ready are both high; an output handshake occurs when out_valid and out_ready are both high.
REQ-016 in_ready is high when out_valid is low or out_ready is high (single-stage, bubble-free pipeline; combinational path from out_ready).
REQ-017 On an input handshake, out_data is loaded on the same clock edge with the result, and out_valid is set; latency is 1 cycle.
REQ-018 On an output handshake without a simultaneous input handshake, out_valid is cleared.
REQ-019 On simultaneous input and output handshakes, out_data is replaced with the new result and out_valid stays high.
REQ-020 When out_valid is high and out_ready is low, out_data and out_valid hold stable.
REQ-021 The true result is sign_extend(in_data) multiplied by 2^in_sel, computed without loss and filled with zeros below bit in_sel.
REQ-022 Overflow occurs when the true result is outside the signed 2*DATA_WIDTH range; it is impossible for in_sel <= DATA_WIDTH.
REQ-023 On an input handshake with overflow, ovf_sticky is set on the same edge.
REQ-024 out_count increments by 1 on each output handshake.
REQ-025 When clr and an overflowing input handshake occur in the same cycle, ovf_sticky ends high.
REQ-026 When clr and an output handshake occur in the same cycle, out_count ends at 1.

Reset
REQ-027 While reset is high, on each clock edge: out_valid=0, out_data=0, ovf_sticky=0, out_count=0.
REQ-028 While reset is high, in_ready is 1 and all handshakes are ignored.
REQ-029 A result held mid-transfer when reset asserts is discarded.

Configuration
REQ-030 With macro PSUM_EXPANDER_SAT_EN defined, an overflowing result saturates: 0x7F..F for a positive true result, 0x80..0 for a negative one.
REQ-031 Without PSUM_EXPANDER_SAT_EN, out_data is the low 2*DATA_WIDTH bits of the true result (wrap), and ovf_sticky still reports overflow.

Verification (DATA_WIDTH=16)
REQ-032 Scenario 1: in_data=0x8001, in_sel=8, out_ready=1 -> next cycle out_valid=1, out_data=0xFF800100, ovf_sticky=0.
REQ-033 Scenario 2: in_data=0x7FFF, in_sel=17 -> ovf_sticky=1; out_data=0x7FFFFFFF with SAT_EN, 0xFFFE0000 without.
REQ-034 Scenario 3: in_data=0x0001, in_sel=31 -> ovf_sticky=1; out_data=0x7FFFFFFF with SAT_EN, 0x80000000 without.
REQ-035 Scenario 4: out_ready=0 for 5 cycles after one accepted input:
- out_data and out_valid stay stable and in_ready=0 throughout;
- raising out_ready together with a new input gives back-to-back outputs and out_count=2.
REQ-036 Scenario 5: back-to-back inputs 0x0001 sel 0..15 with out_ready=1 -> one output per cycle, 0x1<<n in order, out_count=16.
REQ-037 Scenario 6: reset asserted while out_valid=1 and ovf_sticky=1 -> next cycle out_valid=0, out_data=0, ovf_sticky=0, out_count=0, in_ready=1.

Source files
------------

// File: rtl/psum_expander.sv
// Expands a narrow signed psum by a left shift into a 2*DATA_WIDTH word through a 1-deep skid-free register stage.
// Optional saturation on overflow: define PSUM_EXPANDER_SAT_EN (default build wraps).
module psum_expander #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [SEL_WIDTH:0]      in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    ovf_sticky,
  input  logic                    clr,
  output logic [15:0]             out_count
);
  localparam int OW = 2*DATA_WIDTH;
  // Shift amounts reach 2*DATA_WIDTH-1, so 3*DATA_WIDTH bits hold the true result losslessly.
  localparam int XW = 3*DATA_WIDTH;

  logic [XW-1:0] ext, shifted;
  logic          ovf, in_hs, out_hs;
  logic [OW-1:0] result;

  assign ext     = {{(XW-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign shifted = ext << in_sel;
  // Fits in OW signed bits only if everything from bit OW-1 upward is a copy of the sign.
  assign ovf     = (|shifted[XW-1:OW-1]) & ~(&shifted[XW-1:OW-1]);

`ifdef PSUM_EXPANDER_SAT_EN
  always_comb begin
    result = shifted[OW-1:0];
    if (ovf) result = in_data[DATA_WIDTH-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
  end
`else
  assign result = shifted[OW-1:0];
`endif

  assign in_ready = reset | ~out_valid | out_ready;
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      ovf_sticky <= 1'b0;
      out_count  <= '0;
    end else begin
      if (in_hs) begin
        out_data  <= result;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      if (in_hs && ovf)  ovf_sticky <= 1'b1;
      else if (clr)      ovf_sticky <= 1'b0;
      out_count <= (clr ? 16'd0 : out_count) + {15'd0, out_hs};
    end
  end
endmodule

// File: tb/tb_psum_expander.sv
// Directed bench for psum_expander (DATA_WIDTH=16); expectations follow PSUM_EXPANDER_SAT_EN if defined.
module tb_psum_expander;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, ovf_sticky, clr;
  logic [15:0] in_data, out_count;
  logic [4:0]  in_sel;
  logic [31:0] out_data, held;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psum_expander #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .ovf_sticky(ovf_sticky), .clr(clr), .out_count(out_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] s, input logic r);
    in_valid = v; in_data = d; in_sel = s; out_ready = r;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0;
    drive(1'b1, 16'h7FFF, 5'd31, 1'b1);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_ovf", {31'd0, ovf_sticky}, 32'd0);
    chk("rst_count", {16'd0, out_count}, 32'd0);
    reset = 1'b0;

    // Scenario 1
    drive(1'b1, 16'h8001, 5'd8, 1'b1);
    tick();
    chk("s1_valid", {31'd0, out_valid}, 32'd1);
    chk("s1_data", out_data, 32'hFF800100);
    chk("s1_ovf", {31'd0, ovf_sticky}, 32'd0);
    drive(1'b0, 16'h0, 5'd0, 1'b1);
    tick();
    chk("s1_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("s1_count", {16'd0, out_count}, 32'd1);

    // Scenario 2
    drive(1'b1, 16'h7FFF, 5'd17, 1'b1);
    tick();
    chk("s2_ovf", {31'd0, ovf_sticky}, 32'd1);
`ifdef PSUM_EXPANDER_SAT_EN
    chk("s2_data", out_data, 32'h7FFFFFFF);
`else
    chk("s2_data", out_data, 32'hFFFE0000);
`endif
    drive(1'b0, 16'h0, 5'd0, 1'b1);
    tick();
    chk("s2_count", {16'd0, out_count}, 32'd2);
    chk("s2_ovf_sticks", {31'd0, ovf_sticky}, 32'd1);

    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ovf", {31'd0, ovf_sticky}, 32'd0);
    chk("clr_count", {16'd0, out_count}, 32'd0);

    // Scenario 3 with clr in the same cycle as an overflowing input
    clr = 1'b1;
    drive(1'b1, 16'h0001, 5'd31, 1'b1);
    tick(); clr = 1'b0;
    chk("s3_ovf_over_clr", {31'd0, ovf_sticky}, 32'd1);
`ifdef PSUM_EXPANDER_SAT_EN
    chk("s3_data", out_data, 32'h7FFFFFFF);
`else
    chk("s3_data", out_data, 32'h80000000);
`endif

    // Negative overflow, back-to-back after scenario 3; clr with output handshake -> count 1
    clr = 1'b1;
    drive(1'b1, 16'h8000, 5'd17, 1'b1);
    tick(); clr = 1'b0;
    chk("neg_count_clr_hs", {16'd0, out_count}, 32'd1);
    chk("neg_ovf", {31'd0, ovf_sticky}, 32'd1);
`ifdef PSUM_EXPANDER_SAT_EN
    chk("neg_data", out_data, 32'h80000000);
`else
    chk("neg_data", out_data, 32'h00000000);
`endif
    drive(1'b0, 16'h0, 5'd0, 1'b1);
    tick();
    clr = 1'b1; tick(); clr = 1'b0;

    // Scenario 4: backpressure
    drive(1'b1, 16'h1234, 5'd4, 1'b0);
    tick();
    chk("s4_first", out_data, 32'h00012340);
    held = out_data;
    drive(1'b1, 16'h0002, 5'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s4_in_ready_low", {31'd0, in_ready}, 32'd0);
      tick();
      chk("s4_hold_data", out_data, held);
      chk("s4_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("s4_second", out_data, 32'h00000004);
    chk("s4_valid_kept", {31'd0, out_valid}, 32'd1);
    chk("s4_count1", {16'd0, out_count}, 32'd1);
    drive(1'b0, 16'h0, 5'd0, 1'b1);
    tick();
    chk("s4_count2", {16'd0, out_count}, 32'd2);
    chk("s4_drained", {31'd0, out_valid}, 32'd0);

    // Scenario 5: one output per cycle
    clr = 1'b1; tick(); clr = 1'b0;
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, 16'h0001, 5'(n), 1'b1);
      tick();
      chk("s5_data", out_data, 32'd1 << n);
      chk("s5_valid", {31'd0, out_valid}, 32'd1);
    end
    drive(1'b0, 16'h0, 5'd0, 1'b1);
    tick();
    chk("s5_count", {16'd0, out_count}, 32'd16);

    // Scenario 6: reset discards a held, overflowed result
    drive(1'b1, 16'h4000, 5'd20, 1'b0);
    tick();
    chk("s6_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("s6_pre_ovf", {31'd0, ovf_sticky}, 32'd1);
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_valid", {31'd0, out_valid}, 32'd0);
    chk("s6_data", out_data, 32'd0);
    chk("s6_ovf", {31'd0, ovf_sticky}, 32'd0);
    chk("s6_count", {16'd0, out_count}, 32'd0);
    chk("s6_in_ready", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
